// File: rtl/touch_key_debounce.sv
// Touch-key conditioner: 2-flop synchroniser, debounce FSM, press/release strobes and press counter.
// Define TOUCH_LONG_PRESS_EN to build the hold counter and long-press strobe.
module touch_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             touch_key,
  output logic             key_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_press_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES) + 1;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("touch_key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

  logic             s1_q, key_sync_q;
  state_e           state_q, state_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             key_level_q, key_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;

`ifdef TOUCH_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_CYCLES) + 1;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_press_pulse_q, long_press_pulse_d;
`endif

  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    key_level_d     = key_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    press_count_d   = press_count_q;
    unique case (state_q)
      StIdle: begin
        if (key_sync_q) begin
          state_d  = StPressDb;
          db_cnt_d = DbW'(1);
        end
      end
      StPressDb: begin
        if (!key_sync_q) begin
          state_d  = StIdle;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          state_d       = StHeld;
          key_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + CNT_W'(1);
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      StHeld: begin
        if (!key_sync_q) begin
          state_d  = StRelDb;
          db_cnt_d = DbW'(1);
        end
      end
      StRelDb: begin
        // A bounce back to 1 resumes the hold without a new press or a hold restart.
        if (key_sync_q) begin
          state_d = StHeld;
        end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          state_d         = StIdle;
          key_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef TOUCH_LONG_PRESS_EN
  // Saturating at LONG_CYCLES makes the strobe fire at most once per press.
  always_comb begin
    hold_cnt_d         = hold_cnt_q;
    long_press_pulse_d = 1'b0;
    if (press_pulse_d) begin
      hold_cnt_d = '0;
    end else if ((state_q == StHeld || state_q == StRelDb) &&
                 hold_cnt_q != HoldW'(LONG_CYCLES)) begin
      hold_cnt_d         = hold_cnt_q + HoldW'(1);
      long_press_pulse_d = (hold_cnt_q == HoldW'(LONG_CYCLES - 1));
    end
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_q            <= 1'b0;
      key_sync_q      <= 1'b0;
      state_q         <= StIdle;
      db_cnt_q        <= '0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_count_q   <= '0;
`ifdef TOUCH_LONG_PRESS_EN
      hold_cnt_q         <= '0;
      long_press_pulse_q <= 1'b0;
`endif
    end else begin
      s1_q            <= touch_key;
      key_sync_q      <= s1_q;
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      press_count_q   <= press_count_d;
`ifdef TOUCH_LONG_PRESS_EN
      hold_cnt_q         <= hold_cnt_d;
      long_press_pulse_q <= long_press_pulse_d;
`endif
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_count   = press_count_q;
`ifdef TOUCH_LONG_PRESS_EN
  assign long_press_pulse = long_press_pulse_q;
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_touch_key_debounce.sv
// Bench for touch_key_debounce: scenario tasks compare the DUT against a run-length reference
// model every cycle, plus explicit latency / count checks. Honours TOUCH_LONG_PRESS_EN.
module tb_touch_key_debounce;
  localparam int unsigned DB = 10;
  localparam int unsigned LG = 50;
  localparam int unsigned CW = 8;
`ifdef TOUCH_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          touch_key = 1'b0;
  logic          key_level, press_pulse, release_pulse, long_press_pulse;
  logic [CW-1:0] press_count;

  int vecs = 0;
  int fails = 0;
  int presses = 0;

  touch_key_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG),
    .CNT_W          (CW)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .touch_key       (touch_key),
    .key_level       (key_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .press_count     (press_count)
  );

  initial forever #10 sys_clk = ~sys_clk;

  // Reference model: a level change is accepted once the synchronised input has disagreed
  // with the accepted level for DB consecutive samples; long press = LG edges after press.
  logic [1:0] m_samp;
  int         m_run, m_since, m_count;
  logic       m_level, m_press, m_release, m_long;
  int         n_run, n_since, n_count;
  logic       n_level, n_press, n_release, n_long;

  always_comb begin
    n_run     = (m_samp[1] != m_level) ? m_run + 1 : 0;
    n_level   = m_level;
    n_press   = 1'b0;
    n_release = 1'b0;
    n_count   = m_count;
    n_since   = m_since;
    n_long    = 1'b0;
    if (n_run == int'(DB)) begin
      n_run     = 0;
      n_level   = !m_level;
      n_press   = !m_level;
      n_release = m_level;
    end
    if (n_press) begin
      n_count = (m_count + 1) % (1 << CW);
      n_since = 0;
    end else if (LongEn && m_level && m_since < int'(LG)) begin
      n_since = m_since + 1;
      n_long  = (n_since == int'(LG));
    end
  end

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_samp <= 2'b00; m_run <= 0; m_since <= 0; m_count <= 0;
      m_level <= 1'b0; m_press <= 1'b0; m_release <= 1'b0; m_long <= 1'b0;
    end else begin
      m_samp <= {m_samp[0], touch_key};
      m_run <= n_run; m_since <= n_since; m_count <= n_count;
      m_level <= n_level; m_press <= n_press; m_release <= n_release; m_long <= n_long;
    end
  end

  logic [CW+3:0] got, exp;
  assign got = {key_level, press_pulse, release_pulse, long_press_pulse, press_count};
  assign exp = {m_level, m_press, m_release, m_long, m_count[CW-1:0]};

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      vecs++;
      if (got !== '0) begin
        fails++;
        $display("FAIL reset_state t=%0t: got %h expected 0", $time, got);
      end
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int lat = -1;
    int npulse = 0;
    touch_key = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL press_trace edge %0d: got %h expected %h", e, got, exp);
      end
      if (press_pulse) begin
        npulse++;
        if (lat < 0) lat = e;
      end
    end
    presses++;
    vecs++;
    if (lat != int'(DB) + 2 || npulse != 1) begin
      fails++;
      $display("FAIL press_latency: got edge %0d x%0d expected edge %0d x1", lat, npulse, DB + 2);
    end
    vecs++;
    if (key_level !== 1'b1 || press_count !== CW'(presses)) begin
      fails++;
      $display("FAIL press_state: got level %b count %0d expected 1 %0d",
               key_level, press_count, presses);
    end
  endtask

  task automatic test_clean_release();
    int lat = -1;
    int npulse = 0;
    touch_key = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL release_trace edge %0d: got %h expected %h", e, got, exp);
      end
      if (release_pulse) begin
        npulse++;
        if (lat < 0) lat = e;
      end
    end
    vecs++;
    if (lat != int'(DB) + 2 || npulse != 1) begin
      fails++;
      $display("FAIL release_latency: got edge %0d x%0d expected edge %0d x1", lat, npulse, DB + 2);
    end
    vecs++;
    if (key_level !== 1'b0 || press_count !== CW'(presses)) begin
      fails++;
      $display("FAIL release_state: got level %b count %0d expected 0 %0d",
               key_level, press_count, presses);
    end
  endtask

  task automatic test_glitch();
    int widths[3];
    widths[0] = 5;
    widths[1] = int'(DB) - 1;
    widths[2] = int'($urandom_range(DB - 1, 1));
    foreach (widths[k]) begin
      int bad = 0;
      touch_key = 1'b1;
      for (int c = 0; c < widths[k] + 30; c++) begin
        if (c == widths[k]) touch_key = 1'b0;
        @(negedge sys_clk);
        vecs++;
        if (got !== exp) begin
          fails++;
          $display("FAIL glitch_trace width %0d cycle %0d: got %h expected %h",
                   widths[k], c, got, exp);
        end
        if (press_pulse || release_pulse || key_level) bad++;
      end
      vecs++;
      if (bad != 0 || press_count !== CW'(presses)) begin
        fails++;
        $display("FAIL glitch_reject width %0d: got %0d active cycles count %0d expected 0 %0d",
                 widths[k], bad, press_count, presses);
      end
    end
  endtask

  task automatic test_release_bounce();
    int widths[3];
    widths[0] = 4;
    widths[1] = int'(DB) - 1;
    widths[2] = int'($urandom_range(DB - 1, 1));
    touch_key = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL bounce_press_trace: got %h expected %h", got, exp);
      end
    end
    presses++;
    foreach (widths[k]) begin
      int bad = 0;
      touch_key = 1'b0;
      for (int c = 0; c < widths[k] + 25; c++) begin
        if (c == widths[k]) touch_key = 1'b1;
        @(negedge sys_clk);
        vecs++;
        if (got !== exp) begin
          fails++;
          $display("FAIL bounce_trace width %0d cycle %0d: got %h expected %h",
                   widths[k], c, got, exp);
        end
        if (press_pulse || release_pulse || !key_level) bad++;
      end
      vecs++;
      if (bad != 0 || press_count !== CW'(presses)) begin
        fails++;
        $display("FAIL bounce_hold width %0d: got %0d bad cycles count %0d expected 0 %0d",
                 widths[k], bad, press_count, presses);
      end
    end
    touch_key = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL bounce_release_trace: got %h expected %h", got, exp);
      end
    end
  endtask

  task automatic test_long_press();
    int pcyc = -1;
    int lcyc = -1;
    int nlong = 0;
    touch_key = 1'b1;
    for (int e = 1; e <= 180; e++) begin
      if (e == 151) touch_key = 1'b0;
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL long_trace edge %0d: got %h expected %h", e, got, exp);
      end
      if (press_pulse && pcyc < 0) pcyc = e;
      if (long_press_pulse) begin
        nlong++;
        if (lcyc < 0) lcyc = e;
      end
    end
    presses++;
    vecs++;
`ifdef TOUCH_LONG_PRESS_EN
    if (nlong != 1 || lcyc - pcyc != int'(LG)) begin
      fails++;
      $display("FAIL long_press: got %0d pulses, delay %0d expected 1 pulse, delay %0d",
               nlong, lcyc - pcyc, LG);
    end
`else
    if (nlong != 0) begin
      fails++;
      $display("FAIL long_press_disabled: got %0d pulses expected 0", nlong);
    end
`endif
  endtask

  // Release accepted on exactly the edge the hold reaches LG.
  task automatic test_long_release_coincide();
    int rcyc = -1;
    int lcyc = -1;
    touch_key = 1'b1;
    for (int e = 1; e <= 90; e++) begin
      if (e == int'(LG) + 1) touch_key = 1'b0;
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL coincide_trace edge %0d: got %h expected %h", e, got, exp);
      end
      if (release_pulse && rcyc < 0) rcyc = e;
      if (long_press_pulse && lcyc < 0) lcyc = e;
    end
    presses++;
    vecs++;
`ifdef TOUCH_LONG_PRESS_EN
    if (rcyc != int'(DB + 2 + LG) || lcyc != rcyc) begin
      fails++;
      $display("FAIL coincide: got release %0d long %0d expected both %0d", rcyc, lcyc, DB + 2 + LG);
    end
`else
    if (rcyc != int'(DB + 2 + LG) || lcyc != -1) begin
      fails++;
      $display("FAIL coincide: got release %0d long %0d expected %0d and -1", rcyc, lcyc, DB + 2 + LG);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < (1 << CW); p++) begin
      for (int c = 0; c < 28; c++) begin
        touch_key = (c < 14);
        @(negedge sys_clk);
        vecs++;
        if (got !== exp) begin
          fails++;
          $display("FAIL wrap_trace press %0d cycle %0d: got %h expected %h", p, c, got, exp);
        end
      end
    end
    presses += (1 << CW);
    vecs++;
    if (press_count !== CW'(presses)) begin
      fails++;
      $display("FAIL wrap_count: got %0d expected %0d", press_count, presses % (1 << CW));
    end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    touch_key = 1'b1;
    repeat (7) @(negedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    vecs++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_immediate: got %h expected 0", got);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    presses = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL reset_trace edge %0d: got %h expected %h", e, got, exp);
      end
      if (press_pulse && lat < 0) lat = e;
    end
    presses++;
    vecs++;
    if (lat != int'(DB) + 2 || press_count !== CW'(presses)) begin
      fails++;
      $display("FAIL reset_fresh_press: got edge %0d count %0d expected edge %0d count 1",
               lat, press_count, DB + 2);
    end
    touch_key = 1'b0;
    repeat (30) @(negedge sys_clk);
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    for (int s = 0; s < 60; s++) begin
      int len = int'($urandom_range(30, 1));
      lvl = ~lvl;
      touch_key = lvl;
      repeat (len) begin
        @(negedge sys_clk);
        vecs++;
        if (got !== exp) begin
          fails++;
          $display("FAIL random_trace seg %0d: got %h expected %h", s, got, exp);
        end
      end
    end
    touch_key = 1'b0;
    repeat (30) begin
      @(negedge sys_clk);
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random_settle: got %h expected %h", got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_glitch();
    test_release_bounce();
    test_long_press();
    test_long_release_coincide();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
